// File: rtl/card_pkg.sv
// card_pkg: shared FSM states, corner identifiers and address-width helper for the corner scanner.
package card_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SCAN, S_DONE} state_t;
  typedef enum logic {ROI_TL, ROI_BR} roi_t;
  function automatic int addr_w(input int h, input int w);
    return $clog2(h * w);
  endfunction
endpackage

// File: rtl/roi_raster_counter.sv
// roi_raster_counter: raster walk over one corner region with incremental pixel address.
// Ports: load_in/load_addr_in/load_roi_in restart the walk at a corner origin; valid_in/ready_in
// gate advancement; cw_in/ch_in are the inclusive corner extents; x/y/addr/roi give the current
// beat, row_end_out/last_out flag the last column and last pixel (only while valid_in).
module roi_raster_counter
  import card_pkg::*;
#(
  parameter int WIDTH = 240,
  parameter int XW = 8,
  parameter int YW = 9,
  parameter int AW = 17
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          load_in,
  input  logic [AW-1:0] load_addr_in,
  input  roi_t          load_roi_in,
  input  logic          valid_in,
  input  logic          ready_in,
  input  logic [XW-1:0] cw_in,
  input  logic [YW-1:0] ch_in,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic [AW-1:0] addr_out,
  output roi_t          roi_out,
  output logic          row_end_out,
  output logic          last_out
);
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [AW-1:0] r_addr;
  roi_t          r_roi;
  logic          w_row_end;
  logic          w_last;
  logic          w_fire;
  assign w_row_end = r_x == cw_in;
  assign w_last    = w_row_end && r_y == ch_in;
  assign w_fire    = valid_in && ready_in;
  // The final beat is held rather than stepped past, so the outputs keep showing it afterwards.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
      r_roi  <= ROI_TL;
    end else if (load_in) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= load_addr_in;
      r_roi  <= load_roi_in;
    end else if (w_fire && !w_last) begin
      r_x    <= w_row_end ? '0 : r_x + 1'b1;
      r_y    <= w_row_end ? r_y + 1'b1 : r_y;
      r_addr <= w_row_end ? r_addr + AW'(WIDTH) - AW'(cw_in) : r_addr + 1'b1;
    end
  end
  assign x_out       = r_x;
  assign y_out       = r_y;
  assign addr_out    = r_addr;
  assign roi_out     = r_roi;
  assign row_end_out = valid_in && w_row_end;
  assign last_out    = valid_in && w_last;
endmodule

// File: rtl/card_corner_scanner.sv
// card_corner_scanner: validates a card box, sizes its corners and streams corner pixel addresses.
// Ports: start_in/both_corners_in and the four box edges request a scan; addr/x/y/roi/row_end/last
// form each beat under valid_out/ready_in; corner_width/height_out expose the derived corner size;
// busy_out spans the job, done_out pulses after the final beat, err_out pulses on a rejected box.
module card_corner_scanner
  import card_pkg::*;
#(
  parameter  int HEIGHT = 320,
  parameter  int WIDTH  = 240,
  parameter  int DIV_X  = 7,
  parameter  int DIV_Y  = 4,
  localparam int XW     = $clog2(WIDTH),
  localparam int YW     = $clog2(HEIGHT),
  localparam int AW     = addr_w(HEIGHT, WIDTH)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start_in,
  input  logic          both_corners_in,
  input  logic [XW-1:0] left_edge_in,
  input  logic [XW-1:0] right_edge_in,
  input  logic [YW-1:0] top_edge_in,
  input  logic [YW-1:0] bot_edge_in,
  output logic [AW-1:0] addr_out,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic          roi_out,
  output logic          valid_out,
  input  logic          ready_in,
  output logic          row_end_out,
  output logic          last_out,
  output logic [XW-1:0] corner_width_out,
  output logic [YW-1:0] corner_height_out,
  output logic          busy_out,
  output logic          done_out,
  output logic          err_out
);
  state_t        r_state;
  state_t        w_next;
  logic [XW-1:0] r_left;
  logic [XW-1:0] r_right;
  logic [YW-1:0] r_top;
  logic [YW-1:0] r_bot;
  logic          r_both;
  logic [XW-1:0] r_cw;
  logic [YW-1:0] r_ch;
  logic          r_err;
  logic          w_bad;
  logic [XW-1:0] w_cw;
  logic [YW-1:0] w_ch;
  logic [AW-1:0] w_tl_addr;
  logic [AW-1:0] w_br_addr;
  logic          w_fire_last;
  logic          w_br_next;
  logic          w_load;
  logic [AW-1:0] w_load_addr;
  roi_t          w_load_roi;
  roi_t          w_roi;
  logic          w_last;
  assign w_bad = r_right <= r_left || r_bot <= r_top ||
                 r_right > XW'(WIDTH - 1) || r_bot > YW'(HEIGHT - 1);
  assign w_cw = (r_right - r_left) / XW'(DIV_X);
  assign w_ch = (r_bot - r_top) / YW'(DIV_Y);
  assign w_tl_addr = AW'(r_top) * AW'(WIDTH) + AW'(r_left);
  assign w_br_addr = AW'(r_bot - r_ch) * AW'(WIDTH) + AW'(r_right - r_cw);
  assign w_fire_last = valid_out && ready_in && w_last;
  assign w_br_next   = w_roi == ROI_TL && r_both;
  // The bottom-right corner is loaded on the same edge that retires the top-left last beat.
  assign w_load      = (r_state == S_CALC && !w_bad) || (w_fire_last && w_br_next);
  assign w_load_addr = r_state == S_CALC ? w_tl_addr : w_br_addr;
  assign w_load_roi  = r_state == S_CALC ? ROI_TL : ROI_BR;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_left  <= '0;
      r_right <= '0;
      r_top   <= '0;
      r_bot   <= '0;
      r_both  <= 1'b0;
      r_cw    <= '0;
      r_ch    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= r_state == S_CALC && w_bad;
      if (r_state == S_IDLE && start_in) begin
        r_left  <= left_edge_in;
        r_right <= right_edge_in;
        r_top   <= top_edge_in;
        r_bot   <= bot_edge_in;
        r_both  <= both_corners_in;
      end
      if (r_state == S_CALC) begin
        r_cw <= w_cw;
        r_ch <= w_ch;
      end
    end
  end
  always_comb begin
    w_next = r_state == S_IDLE ? (start_in ? S_CALC : S_IDLE) :
             r_state == S_CALC ? (w_bad ? S_IDLE : S_SCAN) :
             r_state == S_SCAN ? (w_fire_last && !w_br_next ? S_DONE : S_SCAN) :
             S_IDLE;
    valid_out = r_state == S_SCAN;
    busy_out  = r_state == S_CALC || r_state == S_SCAN;
    done_out  = r_state == S_DONE;
  end
  roi_raster_counter #(
    .WIDTH(WIDTH),
    .XW   (XW),
    .YW   (YW),
    .AW   (AW)
  ) u_cnt (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .load_in     (w_load),
    .load_addr_in(w_load_addr),
    .load_roi_in (w_load_roi),
    .valid_in    (valid_out),
    .ready_in    (ready_in),
    .cw_in       (r_cw),
    .ch_in       (r_ch),
    .x_out       (x_out),
    .y_out       (y_out),
    .addr_out    (addr_out),
    .roi_out     (w_roi),
    .row_end_out (row_end_out),
    .last_out    (w_last)
  );
  assign roi_out           = w_roi == ROI_BR;
  assign last_out          = w_last;
  assign corner_width_out  = r_cw;
  assign corner_height_out = r_ch;
  assign err_out           = r_err;
endmodule
